// File: rtl/burst_read_ctrl.sv
// burst_read_ctrl: read-sequencing FSM for the Huffman encoder input path.
// A low HREADY seen in IDLE starts a burst of rd_len reads. Each read is
// preceded by WAIT_CYCLES counter-enable cycles, and a clear/done pulse
// closes the burst. abort cuts the burst short.
// Optional build macro BURST_READ_CTRL_PERF_EN adds two outputs:
// burst_cnt (saturating count of completed bursts) and abort_seen
// (sticky flag, set by any accepted abort).
module burst_read_ctrl #(
    parameter int NUM_READS   = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int IDX_W       = (NUM_READS > 1) ? $clog2(NUM_READS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             HREADY,
    input  logic [IDX_W:0]   rd_len,
    input  logic             abort,
    output logic             enable,
    output logic             read_enable,
    output logic [IDX_W-1:0] rd_idx,
    output logic             clear,
    output logic             busy,
    output logic             done
`ifdef BURST_READ_CTRL_PERF_EN
    ,
    output logic [15:0]      burst_cnt,
    output logic             abort_seen
`endif
);

    localparam int WC_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_CYCLES - 1);
    localparam logic [IDX_W:0]  LEN_MAX = (IDX_W + 1)'(NUM_READS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_READ  = 2'd2,
        S_CLEAN = 2'd3
    } state_t;

    state_t            r_state;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [IDX_W-1:0]  r_rd_cnt;
    logic [IDX_W:0]    r_len_q;
    logic              r_enable;
    logic              r_read_en;
    logic [IDX_W-1:0]  r_rd_idx;
    logic              r_clear;
    logic              r_done;

    logic [IDX_W:0]    w_len;
    logic              w_last_read;
    logic              w_read_fire;

    // A length of 0, or one beyond the maximum, means a full-length burst.
    assign w_len       = (rd_len == '0 || rd_len > LEN_MAX) ? LEN_MAX : rd_len;
    assign w_last_read = ({1'b0, r_rd_cnt} == (r_len_q - 1'b1));
    // An abort arriving in READ cancels that cycle's strobe.
    assign w_read_fire = (r_state == S_READ) && !abort;

    // Sequencer: state transitions and outputs decoded from the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_rd_cnt   <= '0;
            r_len_q    <= LEN_MAX;
            r_enable   <= 1'b0;
            r_read_en  <= 1'b0;
            r_rd_idx   <= '0;
            r_clear    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_enable  <= (r_state == S_COUNT);
            r_read_en <= w_read_fire;
            r_clear   <= (r_state == S_CLEAN);
            r_done    <= (r_state == S_CLEAN);
            if (w_read_fire)
                r_rd_idx <= r_rd_cnt;

            case (r_state)
                S_IDLE: begin
                    if (!HREADY) begin
                        r_state    <= S_COUNT;
                        r_len_q    <= w_len;
                        r_wait_cnt <= '0;
                        r_rd_cnt   <= '0;
                    end
                end
                S_COUNT: begin
                    if (abort) begin
                        r_state <= S_CLEAN;
                    end else if (r_wait_cnt == WC_LAST) begin
                        r_state    <= S_READ;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    if (abort || w_last_read) begin
                        r_state <= S_CLEAN;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                        r_state  <= S_COUNT;
                    end
                end
                S_CLEAN: begin
                    // The wait counter is also cleared here, because an
                    // abort taken in COUNT can leave it part-way.
                    r_state    <= S_IDLE;
                    r_rd_cnt   <= '0;
                    r_wait_cnt <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign enable      = r_enable;
    assign read_enable = r_read_en;
    assign rd_idx      = r_rd_idx;
    assign clear       = r_clear;
    assign done        = r_done;
    assign busy        = (r_state != S_IDLE);

`ifdef BURST_READ_CTRL_PERF_EN
    logic [15:0] r_burst_cnt;
    logic        r_abort_seen;

    // Count burst completions (aborted ones included), saturating at the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_burst_cnt <= '0;
        else if (r_state == S_CLEAN && r_burst_cnt != 16'hFFFF)
            r_burst_cnt <= r_burst_cnt + 16'd1;
    end

    // Sticky record of any abort taken while a burst was running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_abort_seen <= 1'b0;
        else if (abort && (r_state == S_COUNT || r_state == S_READ))
            r_abort_seen <= 1'b1;
    end

    assign burst_cnt  = r_burst_cnt;
    assign abort_seen = r_abort_seen;
`endif

endmodule

// File: tb/tb_burst_read_ctrl.sv
// Scoreboard bench for burst_read_ctrl (NUM_READS=8, WAIT_CYCLES=1).
module tb_burst_read_ctrl;

    localparam int NR    = 8;
    localparam int WC    = 1;
    localparam int P     = WC + 1;
    localparam int IDX_W = 3;
    localparam int RL_W  = IDX_W + 1;

    logic             clk;
    logic             reset;
    logic             HREADY;
    logic [RL_W-1:0]  rd_len;
    logic             abort;
    logic             enable;
    logic             read_enable;
    logic [IDX_W-1:0] rd_idx;
    logic             clear;
    logic             busy;
    logic             done;
`ifdef BURST_READ_CTRL_PERF_EN
    logic [15:0]      burst_cnt;
    logic             abort_seen;
`endif

    int n_chk = 0;
    int n_err = 0;
    int exp_q[$];
    int mon_e;

    burst_read_ctrl #(.NUM_READS(NR), .WAIT_CYCLES(WC), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .HREADY      (HREADY),
        .rd_len      (rd_len),
        .abort       (abort),
        .enable      (enable),
        .read_enable (read_enable),
        .rd_idx      (rd_idx),
        .clear       (clear),
        .busy        (busy),
        .done        (done)
`ifdef BURST_READ_CTRL_PERF_EN
        ,
        .burst_cnt   (burst_cnt),
        .abort_seen  (abort_seen)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference FSM phase at interval j of an n-read burst.
    // 0=idle, 1=count, 2=read, 3=clean.
    function automatic int st(input int j, input int n);
        if (j >= 1 && j <= n * P) return (((j - 1) % P) < WC) ? 1 : 2;
        if (j == n * P + 1) return 3;
        return 0;
    endfunction

    // Expected {busy, enable, read_enable, clear} at interval k.
    function automatic int wexp(input int k, input int n);
        return ((st(k, n) != 0) ? 8 : 0) + ((st(k - 1, n) == 1) ? 4 : 0) +
               ((st(k - 1, n) == 2) ? 2 : 0) + ((st(k - 1, n) == 3) ? 1 : 0);
    endfunction

    // Each read strobe pops the next expected index from the queue.
    always @(negedge clk) begin
        if (read_enable) begin
            if (exp_q.size() == 0) begin
                chk("rd_extra", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rd_idx", int'(rd_idx), mon_e);
            end
        end
        if (clear || done) chk("clr_eq_done", int'(clear), int'(done));
    end

    // Run one or more bursts. ab >= 0 aborts during the READ of read ab.
    // HREADY stays low for intervals below lo. tog toggles HREADY and
    // changes rd_len while the burst is running.
    task automatic burst(input string tag, input int len, input int ab,
                         input int lo, input bit tog, input int reps);
        int n, nr, ndone, lastk, expk;
        bit wave;
        n     = (len == 0 || len > NR) ? NR : len;
        nr    = (ab >= 0) ? ab : n;
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < nr; i++) exp_q.push_back(i);
        wave  = (ab < 0 && reps == 1);
        expk  = (ab >= 0) ? (ab + 1) * P + 2 : reps * (n * P + 2);
        ndone = 0;
        lastk = -1;
        rd_len = RL_W'(len);
        HREADY = 1'b0;
        abort  = 1'b0;
        for (int k = 1; k <= expk + 2; k++) begin
            @(negedge clk);
            if (k < lo) HREADY = 1'b0;
            else if (tog && k <= 2 * n) HREADY = (k % 2 == 1);
            else HREADY = 1'b1;
            if (tog) rd_len = RL_W'(1);
            abort = (ab >= 0 && k == (ab + 1) * P);
            if (done) begin
                ndone++;
                lastk = k;
            end
            if (wave)
                chk({tag, "_wave"}, int'({busy, enable, read_enable, clear}), wexp(k, n));
        end
        abort  = 1'b0;
        HREADY = 1'b1;
        repeat (2) @(negedge clk);
        chk({tag, "_ndone"}, ndone, reps);
        chk({tag, "_donek"}, lastk, expk);
        chk({tag, "_q"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        bit found;
        reset  = 1'b1;
        HREADY = 1'b1;
        abort  = 1'b0;
        rd_len = '0;
        #1 chk("rst_out", int'({enable, read_enable, clear, done, busy, rd_idx}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle with HREADY high: nothing moves.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle", int'({enable, read_enable, clear, done, busy}), 0);
        end

        burst("basic",  2,  -1, 1, 1'b0, 1);
        burst("len0",   0,  -1, 1, 1'b0, 1);
        burst("len11",  11, -1, 1, 1'b0, 1);
        burst("len1",   1,  -1, 1, 1'b0, 1);
        burst("len8",   8,  -1, 1, 1'b0, 1);
        burst("abort",  5,   2, 1, 1'b0, 1);
        burst("abort0", 3,   0, 1, 1'b0, 1);
        burst("b2b",    1,  -1, 5, 1'b0, 2);
        burst("tog",    3,  -1, 1, 1'b1, 1);

        // Reset asserted mid-burst while the counter strobe is high.
        rd_len = RL_W'(4);
        HREADY = 1'b0;
        found  = 1'b0;
        for (int k = 1; k <= 10 && !found; k++) begin
            @(negedge clk);
            HREADY = 1'b1;
            if (enable) found = 1'b1;
        end
        chk("rst_en_seen", int'(found), 1);
        #2 reset = 1'b1;
        #1 chk("rst_async", int'({enable, read_enable, clear, done, busy, rd_idx}), 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        burst("post_rst", 3, -1, 1, 1'b0, 1);

`ifdef BURST_READ_CTRL_PERF_EN
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("perf_rst_cnt", int'(burst_cnt), 0);
        chk("perf_rst_ab", int'(abort_seen), 0);
        burst("p1", 2, -1, 1, 1'b0, 1);
        burst("p2", 1, -1, 1, 1'b0, 1);
        burst("p3", 3, -1, 1, 1'b0, 1);
        chk("perf_ab_clr", int'(abort_seen), 0);
        burst("p4", 3,  1, 1, 1'b0, 1);
        chk("perf_cnt4", int'(burst_cnt), 4);
        chk("perf_ab_set", int'(abort_seen), 1);
        force dut.r_burst_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.r_burst_cnt;
        burst("p5", 1, -1, 1, 1'b0, 1);
        burst("p6", 1, -1, 1, 1'b0, 1);
        chk("perf_sat", int'(burst_cnt), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
